// File: rtl/chaos_prng_pkg.sv
// Shared types and helpers for the chaotic PRNG stream generator.
package chaos_prng_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } fsm_state_e;

  localparam int DIM_DEFAULT = 3;
  localparam int ITER_CYCLES = DIM_DEFAULT * (DIM_DEFAULT + 1);

  function automatic int iter_cycles(input int dim);
    return dim * (dim + 1);
  endfunction

  // Low (width - eps_shift) bits set; callers truncate to their word width.
  function automatic logic [63:0] saw_mask(input int width, input int eps_shift);
    return (64'd1 << (width - eps_shift)) - 64'd1;
  endfunction

endpackage

// File: rtl/chaos_prng_stream_if.sv
// Valid/ready output stream carrying one packed DIM-word state vector.
interface chaos_prng_stream_if #(
  parameter int WIDTH = 32,
  parameter int DIM   = 3
) ();
  logic                 m_valid;
  logic                 m_ready;
  logic [DIM*WIDTH-1:0] m_data;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/chaos_prng_mac.sv
// Single time-shared multiplier with a registered accumulator; the add term is
// either the raw product or its sawtooth (low-bit masked) value.
module chaos_prng_mac
  import chaos_prng_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int EPS_SHIFT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en_i,
  input  logic             clear_i,
  input  logic             saw_sel_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o
);

  localparam logic [WIDTH-1:0] SAW_MASK = WIDTH'(saw_mask(WIDTH, EPS_SHIFT));

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] prod;
  logic [WIDTH-1:0] term;

  assign prod  = a_i * b_i;
  assign term  = saw_sel_i ? (prod & SAW_MASK) : prod;
  assign sum_o = (clear_i ? '0 : acc_q) + term;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= sum_o;
    end
  end

endmodule

// File: rtl/chaos_prng_stream.sv
// N-channel chaotic PRNG: x' = A*x + saw(sigma*x) mod 2^WIDTH, one multiply per cycle,
// with warm-up discard and a backpressured output stream. Optional macro: CHAOS_PRNG_ZERO_RESEED_EN.
module chaos_prng_stream
  import chaos_prng_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DIM       = DIM_DEFAULT,
  parameter int WARMUP    = 16,
  parameter int EPS_SHIFT = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     seed_load,
  input  logic [DIM*WIDTH-1:0]     seed_x,
  input  logic [DIM*DIM*WIDTH-1:0] a_coef,
  input  logic [WIDTH-1:0]         sigma,
  input  logic                     run,
  chaos_prng_stream_if.master      strm,
  output logic                     degenerate,
  output logic                     busy
);

  localparam int IDX_W = $clog2(DIM + 1);
  localparam int CNT_W = $clog2(WARMUP + 2);
  localparam logic [IDX_W-1:0] ROW_LAST = IDX_W'(DIM - 1);
  localparam logic [IDX_W-1:0] COL_SAW  = IDX_W'(DIM);

  fsm_state_e           state_q, state_d;
  logic [IDX_W-1:0]     row_q, row_d;
  logic [IDX_W-1:0]     col_q, col_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 m_valid_q, m_valid_d;
  logic [DIM*WIDTH-1:0] m_data_q, m_data_d;
  logic                 degen_q, degen_d;

  logic [WIDTH-1:0]     x_q      [DIM];
  logic [WIDTH-1:0]     shadow_q [DIM];
  logic [WIDTH-1:0]     a_q      [DIM][DIM];
  logic [WIDTH-1:0]     sigma_q;
  logic [WIDTH-1:0]     x_new    [DIM];
  logic [WIDTH-1:0]     x_fix    [DIM];
  logic [DIM*WIDTH-1:0] x_flat;
  logic [DIM*WIDTH-1:0] xfix_flat;

  logic             col_saw, iter_last, hs, out_free, new_zero;
  logic             load_out, load_from_new;
  logic [WIDTH-1:0] mul_a, mul_b, mac_sum;

  assign col_saw   = (col_q == COL_SAW);
  assign iter_last = (state_q == CALC) && (row_q == ROW_LAST) && col_saw;
  assign hs        = m_valid_q && strm.m_ready;
  assign out_free  = !m_valid_q || strm.m_ready;

  // Columns 0..DIM-1 multiply A[row][col]*x[col]; the extra column forms sigma*x[row].
  always_comb begin
    mul_a = sigma_q;
    mul_b = '0;
    for (int i = 0; i < DIM; i++) begin
      if (row_q == IDX_W'(i)) begin
        if (col_saw) mul_b = x_q[i];
        for (int j = 0; j < DIM; j++) begin
          if (!col_saw && col_q == IDX_W'(j)) mul_a = a_q[i][j];
        end
      end
      if (!col_saw && col_q == IDX_W'(i)) mul_b = x_q[i];
    end
  end

  chaos_prng_mac #(
    .WIDTH     (WIDTH),
    .EPS_SHIFT (EPS_SHIFT)
  ) u_mac (
    .clk       (clk),
    .reset_n   (reset_n),
    .en_i      (state_q == CALC),
    .clear_i   (col_q == '0),
    .saw_sel_i (col_saw),
    .a_i       (mul_a),
    .b_i       (mul_b),
    .sum_o     (mac_sum)
  );

  // The last row is still in the MAC when the iteration completes, so it bypasses the shadow.
  genvar gi;
  generate
    for (gi = 0; gi < DIM; gi++) begin : g_chan
      assign x_new[gi] = (gi == DIM - 1) ? mac_sum : shadow_q[gi];
`ifdef CHAOS_PRNG_ZERO_RESEED_EN
      assign x_fix[gi] = new_zero ? WIDTH'(1) : x_new[gi];
`else
      assign x_fix[gi] = x_new[gi];
`endif
      assign x_flat[gi*WIDTH +: WIDTH]    = x_q[gi];
      assign xfix_flat[gi*WIDTH +: WIDTH] = x_fix[gi];
    end
  endgenerate

  always_comb begin
    new_zero = 1'b1;
    for (int i = 0; i < DIM; i++) begin
      if (x_new[i] != '0) new_zero = 1'b0;
    end
  end

  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    col_d         = col_q;
    cnt_d         = cnt_q;
    load_out      = 1'b0;
    load_from_new = 1'b0;
    case (state_q)
      IDLE: begin
        if (run) state_d = CALC;
      end
      CALC: begin
        if (col_saw) begin
          col_d = '0;
          row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
        if (iter_last) begin
          if (cnt_q != '0) begin
            cnt_d   = cnt_q - 1'b1;
            state_d = run ? CALC : IDLE;
          end else if (out_free) begin
            load_out      = 1'b1;
            load_from_new = 1'b1;
            state_d       = run ? CALC : IDLE;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (hs) begin
          load_out = 1'b1;
          state_d  = run ? CALC : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (seed_load) begin
      state_d       = run ? CALC : IDLE;
      row_d         = '0;
      col_d         = '0;
      cnt_d         = CNT_W'(WARMUP);
      load_out      = 1'b0;
      load_from_new = 1'b0;
    end
  end

  always_comb begin
    m_valid_d = m_valid_q;
    if (hs)        m_valid_d = 1'b0;
    if (load_out)  m_valid_d = 1'b1;
    if (seed_load) m_valid_d = 1'b0;
    m_data_d = m_data_q;
    if (load_out) m_data_d = load_from_new ? xfix_flat : x_flat;
    degen_d = degen_q;
    if (iter_last && new_zero) degen_d = 1'b1;
    if (seed_load)             degen_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      degen_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      degen_q   <= degen_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sigma_q <= '0;
      for (int i = 0; i < DIM; i++) begin
        x_q[i]      <= '0;
        shadow_q[i] <= '0;
        for (int j = 0; j < DIM; j++) a_q[i][j] <= '0;
      end
    end else begin
      if (seed_load) begin
        sigma_q <= sigma;
        for (int i = 0; i < DIM; i++) begin
          x_q[i] <= seed_x[i*WIDTH +: WIDTH];
          for (int j = 0; j < DIM; j++) a_q[i][j] <= a_coef[(i*DIM+j)*WIDTH +: WIDTH];
        end
      end else begin
        if (iter_last) begin
          for (int i = 0; i < DIM; i++) x_q[i] <= x_fix[i];
        end
        if (state_q == CALC && col_saw) begin
          for (int i = 0; i < DIM; i++) begin
            if (row_q == IDX_W'(i)) shadow_q[i] <= mac_sum;
          end
        end
      end
    end
  end

  assign strm.m_valid = m_valid_q;
  assign strm.m_data  = m_data_q;
  assign degenerate   = degen_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_chaos_prng_stream.sv
// Self-checking bench: WIDTH=8, DIM=2 with two instances (WARMUP=0 and WARMUP=1).
module tb_chaos_prng_stream;

  localparam int W = 8;
  localparam int D = 2;

  logic        clk = 1'b0;
  logic        reset_n, seed_load, run;
  logic [15:0] seed_x;
  logic [31:0] a_coef;
  logic [7:0]  sigma;
  logic        deg0, busy0, deg1, busy1;

  always #5 clk = ~clk;

  chaos_prng_stream_if #(.WIDTH(W), .DIM(D)) s0 ();
  chaos_prng_stream_if #(.WIDTH(W), .DIM(D)) s1 ();
  assign s1.m_ready = 1'b1;

  chaos_prng_stream #(.WIDTH(W), .DIM(D), .WARMUP(0), .EPS_SHIFT(4)) dut (
    .clk(clk), .reset_n(reset_n), .seed_load(seed_load), .seed_x(seed_x),
    .a_coef(a_coef), .sigma(sigma), .run(run), .strm(s0.master),
    .degenerate(deg0), .busy(busy0)
  );

  chaos_prng_stream #(.WIDTH(W), .DIM(D), .WARMUP(1), .EPS_SHIFT(4)) dut_w (
    .clk(clk), .reset_n(reset_n), .seed_load(seed_load), .seed_x(seed_x),
    .a_coef(a_coef), .sigma(sigma), .run(run), .strm(s1.master),
    .degenerate(deg1), .busy(busy1)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  sig;
    logic [15:0] seed;
    logic [15:0] exp1;
    logic [15:0] exp2;
    logic        exp_deg;
  } vec_t;

  vec_t vecs [9];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seed(input logic [31:0] a, input logic [7:0] s, input logic [15:0] x);
    a_coef    = a;
    sigma     = s;
    seed_x    = x;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
  endtask

  // Reference iteration from the defining equation, using plain integer arithmetic.
  function automatic logic [15:0] step(input logic [31:0] a, input logic [7:0] s,
                                       input logic [15:0] x, output logic z);
    int xv [2];
    int nx [2];
    xv[0] = int'(x[7:0]);
    xv[1] = int'(x[15:8]);
    nx[0] = (int'(a[7:0])   * xv[0] + int'(a[15:8])  * xv[1] + (int'(s) * xv[0]) % 16) % 256;
    nx[1] = (int'(a[23:16]) * xv[0] + int'(a[31:24]) * xv[1] + (int'(s) * xv[1]) % 16) % 256;
    z = (nx[0] == 0) && (nx[1] == 0);
`ifdef CHAOS_PRNG_ZERO_RESEED_EN
    if (z) begin
      nx[0] = 1;
      nx[1] = 1;
    end
`endif
    return {nx[1][7:0], nx[0][7:0]};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] x1, x2, x3, d1, d2, dw;
    logic        z1, z2, z3;
    int          fc, wc, nv, n;

    reset_n = 1'b0; seed_load = 1'b0; run = 1'b0;
    seed_x = '0; a_coef = '0; sigma = '0;
    s0.m_ready = 1'b1;

    vecs[0] = '{a: 32'h01010102, sig: 8'd3, seed: 16'h0001, exp1: 16'h0105, exp2: 16'h091A, exp_deg: 1'b0};
    vecs[1] = '{a: 32'h01010102, sig: 8'd3, seed: 16'h0100, exp1: 16'h0401, exp2: 16'h1109, exp_deg: 1'b0};
`ifdef CHAOS_PRNG_ZERO_RESEED_EN
    vecs[2] = '{a: 32'h01010102, sig: 8'd3, seed: 16'h0000, exp1: 16'h0101, exp2: 16'h0506, exp_deg: 1'b1};
`else
    vecs[2] = '{a: 32'h01010102, sig: 8'd3, seed: 16'h0000, exp1: 16'h0000, exp2: 16'h0000, exp_deg: 1'b1};
`endif
    for (int k = 3; k < 9; k++) begin
      vecs[k].a    = $urandom;
      vecs[k].sig  = 8'($urandom);
      vecs[k].seed = 16'($urandom);
      x1 = step(vecs[k].a, vecs[k].sig, vecs[k].seed, z1);
      x2 = step(vecs[k].a, vecs[k].sig, x1, z2);
      x3 = step(vecs[k].a, vecs[k].sig, x2, z3);
      vecs[k].exp1    = x1;
      vecs[k].exp2    = x2;
      vecs[k].exp_deg = z1 | z2 | z3;
    end

    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    check("rst_valid", 32'(s0.m_valid), 32'd0);
    check("rst_data",  32'(s0.m_data),  32'd0);
    check("rst_deg",   32'(deg0),       32'd0);
    check("rst_busy",  32'(busy0),      32'd0);

    // Table vectors: each seed load lands mid-iteration of the previous one.
    run = 1'b1;
    for (int v = 0; v < 9; v++) begin
      load_seed(vecs[v].a, vecs[v].sig, vecs[v].seed);
      fc = -1; wc = -1; nv = 0; d1 = '0; d2 = '0; dw = '0;
      for (int c = 1; c <= 20; c++) begin
        if (s0.m_valid) begin
          if (nv == 0) begin
            fc = c;
            d1 = s0.m_data;
          end else if (nv == 1) begin
            d2 = s0.m_data;
          end
          nv++;
        end
        if (s1.m_valid && wc < 0) begin
          wc = c;
          dw = s1.m_data;
        end
        tick();
      end
      $display("vec %0d seed=%04h first@%0d data=%04h second=%04h warm@%0d data=%04h deg=%0d/%0d",
               v, vecs[v].seed, fc, d1, d2, wc, dw, deg0, deg1);
      check("lat_first",  32'(fc),  32'd7);
      check("data_first", 32'(d1),  32'(vecs[v].exp1));
      check("data_next",  32'(d2),  32'(vecs[v].exp2));
      check("lat_warm",   32'(wc),  32'd13);
      check("data_warm",  32'(dw),  32'(vecs[v].exp2));
      check("deg",        32'(deg0), 32'(vecs[v].exp_deg));
      check("deg_warm",   32'(deg1), 32'(vecs[v].exp_deg));
    end

    // Backpressure: first word held for 20 cycles, HOLD keeps busy high.
    s0.m_ready = 1'b0;
    load_seed(vecs[0].a, vecs[0].sig, vecs[0].seed);
    n = 1;
    while (!s0.m_valid && n < 40) begin
      tick();
      n++;
    end
    check("bp_lat", 32'(n), 32'd7);
    for (int i = 0; i < 20; i++) begin
      check("bp_hold", 32'({s0.m_valid, s0.m_data}), 32'h10105);
      if (i == 10) check("bp_busy", 32'(busy0), 32'd1);
      tick();
    end
    s0.m_ready = 1'b1;
    tick();
    $display("backpressure release valid=%0d data=%04h", s0.m_valid, s0.m_data);
    check("bp_next", 32'({s0.m_valid, s0.m_data}), 32'h1091A);
    tick();
    check("bp_drop", 32'(s0.m_valid), 32'd0);

    // Asynchronous reset while stalled in HOLD with the degenerate flag set.
    s0.m_ready = 1'b0;
    load_seed(vecs[2].a, vecs[2].sig, vecs[2].seed);
    repeat (15) tick();
    check("hold_busy",  32'(busy0), 32'd1);
    check("hold_deg",   32'(deg0),  32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    $display("async reset valid=%0d data=%04h deg=%0d busy=%0d", s0.m_valid, s0.m_data, deg0, busy0);
    check("arst_valid", 32'(s0.m_valid), 32'd0);
    check("arst_data",  32'(s0.m_data),  32'd0);
    check("arst_deg",   32'(deg0),       32'd0);
    check("arst_busy",  32'(busy0),      32'd0);
    run = 1'b0;
    tick();
    reset_n    = 1'b1;
    s0.m_ready = 1'b1;
    tick();

    // run dropped mid-iteration: finish, idle, then resume from stored state.
    run = 1'b1;
    load_seed(vecs[0].a, vecs[0].sig, vecs[0].seed);
    tick();
    tick();
    check("run_busy", 32'(busy0), 32'd1);
    run = 1'b0;
    n = 0;
    while (!s0.m_valid && n < 20) begin
      tick();
      n++;
    end
    check("run_lat",   32'(n), 32'd4);
    check("run_data",  32'(s0.m_data), 32'h0105);
    check("run_idle",  32'(busy0), 32'd0);
    repeat (4) tick();
    check("run_still", 32'({busy0, s0.m_valid}), 32'd0);
    run = 1'b1;
    n = 0;
    while (!s0.m_valid && n < 20) begin
      tick();
      n++;
    end
    $display("resume after %0d cycles data=%04h", n, s0.m_data);
    check("resume_lat",  32'(n), 32'd7);
    check("resume_data", 32'(s0.m_data), 32'h091A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/chaos_prng_stream.md
Name: chaos_prng_stream

Overview:
- Parametrised successor to the three-channel chaotic PRNG. Iterates an N-dimensional integer affine map with sawtooth perturbation: x' = A·x + saw(sigma·x) mod 2^WIDTH.
- Fixed-point only, with no floating-point IP. Uses one time-shared multiplier.
- Adds seed reload, warm-up discard, a valid/ready output stream with backpressure, and degenerate-state detection.
- Feeds the keystream/permutation stages of the image cipher.

Parameters:
- WIDTH, 32, bits per state word and per coefficient; all arithmetic is modulo 2^WIDTH.
- DIM, 3, number of channels (state dimension), 1..8.
- WARMUP, 16, iterations discarded after each seed load; 0 allowed.
- EPS_SHIFT, 4, sawtooth modulus is 2^(WIDTH-EPS_SHIFT), so saw(v) = v & (2^(WIDTH-EPS_SHIFT)-1).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- seed_load  in  1  single-cycle pulse: snapshot seed_x, a_coef and sigma; restart
- seed_x  in  DIM*WIDTH  initial state; channel i at [i*WIDTH +: WIDTH]
- a_coef  in  DIM*DIM*WIDTH  matrix; A[i][j] at index i*DIM+j
- sigma  in  WIDTH  perturbation gain
- run  in  1  level enable for iterating
- m_valid  out  1  output word valid
- m_ready  in  1  consumer accepts when m_valid&&m_ready
- m_data  out  DIM*WIDTH  state after iteration; same packing as seed_x
- degenerate  out  1  sticky; state became all-zero
- busy  out  1  high while not in IDLE

Behaviour:
- Reset: m_valid=0, m_data=0, degenerate=0, busy=0, FSM=IDLE. The state, coefficient and sigma registers are cleared to 0.
- FSM states: IDLE, CALC, HOLD.
- seed_load, in any state: takes priority over everything.
  - Registers the snapshot and clears m_valid, degenerate and the warm-up counter (cnt=WARMUP).
  - Aborts any iteration in flight.
  - Goes to CALC if run=1, else IDLE.
- IDLE -> CALC when run=1.
- CALC: row-serial and column-serial, with one multiply per cycle.
  - For row i: DIM cycles accumulate A[i][j]*x[j].
  - Then one cycle adds saw(sigma*x[i]).
  - Row results go to a shadow register. Every row uses the pre-iteration x (Jacobi update).
  - One iteration takes exactly DIM*(DIM+1) cycles. On the last cycle the shadow is copied into x.
- End of iteration:
  - If cnt>0: decrement cnt, do not output, continue CALC (or go to IDLE if run=0).
  - Else, if the output register is free (m_valid=0, or a handshake happens this cycle): load m_data, set m_valid=1 next cycle, continue.
  - Else: go to HOLD.
- HOLD: wait until m_valid&&m_ready. In that cycle load m_data from x; m_valid stays 1. Then continue as above.
- Output stream:
  - m_data is stable while m_valid=1 and m_ready=0.
  - m_valid drops after a handshake unless a new word is loaded in the same cycle.
- Latency: with seed_load at cycle 0 and run=1, the first m_valid is high at cycle 1+(WARMUP+1)*DIM*(DIM+1). Sustained throughput is one word per DIM*(DIM+1) cycles.
- run deasserted mid-iteration: the iteration completes, then the FSM goes to IDLE. It resumes from the stored state.
- Degenerate state: after any iteration, if the new x is all-zero, set degenerate (sticky until seed_load). This includes warm-up iterations.
- Simultaneous seed_load and handshake: the handshake completes; m_valid goes to 0; the new seed wins.

Optional Feature:
- Macro: CHAOS_PRNG_ZERO_RESEED_EN.
- Defined: an all-zero x at the end of an iteration is replaced by x[i]=1 for all i, and degenerate is still set. The replaced value is what is stored and output.
- Undefined: the zero state persists, and the output stays all-zero.

Decomposition:
- Package chaos_prng_pkg holds:
  - fsm state enum (IDLE, CALC, HOLD);
  - function saw_mask(WIDTH, EPS_SHIFT);
  - localparam ITER_CYCLES = DIM*(DIM+1).
- One natural sub-module, chaos_prng_mac: a registered WIDTH-bit multiply-accumulate with clear and add-term select. The top level holds the FSM, indices, shadow state and output register.

Test Plan:
- Basic iteration. Setup: WIDTH=8, DIM=2, WARMUP=0, EPS_SHIFT=4, A=[[2,1],[1,1]], sigma=3, seed=(1,0), run=1, m_ready=1. Expected:
  - m_valid at cycle 7 with m_data=(5,1);
  - next word at cycle 13 with (26,9).
- Warm-up: same setup with WARMUP=1. First m_valid at cycle 13 with (26,9). No earlier valid.
- Backpressure: m_ready=0 for 20 cycles after the first valid.
  - (5,1) is held stable; busy=1 in HOLD.
  - On release, (5,1) handshakes and (26,9) follows in the next cycle.
- Mid-iteration controls:
  - seed_load asserted mid-CALC with seed=(0,1): the old iteration is aborted. The first valid is 7 cycles later with (1,4), since row0=0+1+0=1 and row1=1+3=4.
  - run dropped mid-iteration: the iteration finishes, busy falls, and the FSM resumes on run=1.
- Degenerate seed: seed=(0,0).
  - Without the macro: output (0,0) and degenerate=1.
  - With CHAOS_PRNG_ZERO_RESEED_EN: output (1,1) and degenerate=1.
- Reset: reset_n pulsed low mid-HOLD. All outputs go to 0 immediately and the FSM returns to IDLE.
